// File: rtl/clint_bus_arbiter.sv
// clint_bus_arbiter: round-robin sharing of the CLINT register port between the LSU and debug requesters
module clint_bus_arbiter #(
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] CLINT_BASE = 64'h0000_0000_0200_0000,
   parameter logic [DATA_WIDTH-1:0] CLINT_MASK = 64'hFFFF_FFFF_FFFF_0000
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  m0_req_valid_i,
   output logic                  m0_req_ready_o,
   input  logic [DATA_WIDTH-1:0] m0_req_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata_i,
   input  logic                  m0_req_wen_i,
   output logic                  m0_rsp_valid_o,
   input  logic                  m0_rsp_ready_i,
   output logic [DATA_WIDTH-1:0] m0_rsp_rdata_o,
   output logic                  m0_rsp_err_o,
   input  logic                  m1_req_valid_i,
   output logic                  m1_req_ready_o,
   input  logic [DATA_WIDTH-1:0] m1_req_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata_i,
   input  logic                  m1_req_wen_i,
   output logic                  m1_rsp_valid_o,
   input  logic                  m1_rsp_ready_i,
   output logic [DATA_WIDTH-1:0] m1_rsp_rdata_o,
   output logic                  m1_rsp_err_o,
   output logic [DATA_WIDTH-1:0] clint_addr_o,
   output logic [DATA_WIDTH-1:0] clint_wdata_o,
   output logic                  clint_wen_o,
   output logic                  clint_sel_o,
   input  logic [DATA_WIDTH-1:0] clint_rdata_i
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  last_q, last_d, gnt_q, gnt_d, wen_q, wen_d, err_q, err_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic                  gnt_c, ok;

   // grant selection, address decode and all port outputs
   always_comb begin
      gnt_c          = (m0_req_valid_i && m1_req_valid_i) ? ~last_q : m1_req_valid_i;
      ok             = ((addr_q & CLINT_MASK) == CLINT_BASE) && addr_q[2:0] == 3'd0 &&
                       (addr_q[15:0] == 16'h4000 || addr_q[15:0] == 16'hbff8);
      m0_req_ready_o = state_q == IDLE && m0_req_valid_i && !gnt_c;
      m1_req_ready_o = state_q == IDLE && m1_req_valid_i && gnt_c;
      m0_rsp_valid_o = state_q == RESP && !gnt_q;
      m1_rsp_valid_o = state_q == RESP && gnt_q;
      m0_rsp_rdata_o = m0_rsp_valid_o ? rdata_q : '0;
      m1_rsp_rdata_o = m1_rsp_valid_o ? rdata_q : '0;
      m0_rsp_err_o   = m0_rsp_valid_o && err_q;
      m1_rsp_err_o   = m1_rsp_valid_o && err_q;
      clint_sel_o    = state_q == ISSUE && ok;
      clint_wen_o    = clint_sel_o && wen_q;
      clint_addr_o   = addr_q;
      clint_wdata_o  = wdata_q;
   end

   // transaction sequencing: latch on grant, issue, capture registered read data, respond
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wen_d   = wen_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (m0_req_valid_i || m1_req_valid_i) begin
            gnt_d   = gnt_c;
            addr_d  = gnt_c ? m1_req_addr_i : m0_req_addr_i;
            wdata_d = gnt_c ? m1_req_wdata_i : m0_req_wdata_i;
            wen_d   = gnt_c ? m1_req_wen_i : m0_req_wen_i;
            state_d = ISSUE;
         end
         ISSUE: begin
            err_d   = !ok;
            rdata_d = '0;
            state_d = ok ? WAIT : RESP;
         end
         WAIT: begin
            rdata_d = wen_q ? '0 : clint_rdata_i;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: if (gnt_q ? m1_rsp_ready_i : m0_rsp_ready_i) begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
      endcase
   end

   // state registers; last_q resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wen_q   <= wen_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_clint_bus_arbiter.sv
// tb_clint_bus_arbiter: randomized and directed checks of the CLINT arbiter against a transaction-level model
module tb_clint_bus_arbiter;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_v = '0, req_w = '0, req_r, rsp_v, rsp_r = '0, rsp_e;
   logic [63:0] req_a [2];
   logic [63:0] req_d [2];
   logic [63:0] rsp_d [2];
   logic [63:0] clint_addr, clint_wdata, clint_rdata = '0;
   logic        clint_wen, clint_sel;
   logic [63:0] mtime = 64'd1000, mtimecmp = '0, shadow_cmp = '0, prev_mt = '0;
   int          checks = 0, failures = 0, last_m = 1;
   logic [63:0] addrs [5] = '{64'h0200_4000, 64'h0200_bff8, 64'h0200_1000, 64'h0200_4004, 64'h0300_4000};

   clint_bus_arbiter dut (
      .clock_i(clock), .reset_i(reset_n),
      .m0_req_valid_i(req_v[0]), .m0_req_ready_o(req_r[0]), .m0_req_addr_i(req_a[0]),
      .m0_req_wdata_i(req_d[0]), .m0_req_wen_i(req_w[0]), .m0_rsp_valid_o(rsp_v[0]),
      .m0_rsp_ready_i(rsp_r[0]), .m0_rsp_rdata_o(rsp_d[0]), .m0_rsp_err_o(rsp_e[0]),
      .m1_req_valid_i(req_v[1]), .m1_req_ready_o(req_r[1]), .m1_req_addr_i(req_a[1]),
      .m1_req_wdata_i(req_d[1]), .m1_req_wen_i(req_w[1]), .m1_rsp_valid_o(rsp_v[1]),
      .m1_rsp_ready_i(rsp_r[1]), .m1_rsp_rdata_o(rsp_d[1]), .m1_rsp_err_o(rsp_e[1]),
      .clint_addr_o(clint_addr), .clint_wdata_o(clint_wdata), .clint_wen_o(clint_wen),
      .clint_sel_o(clint_sel), .clint_rdata_i(clint_rdata)
   );

   always #5 clock = ~clock;

   // behavioural CLINT: free-running mtime, registered read data one cycle after select
   always @(posedge clock) begin
      mtime <= mtime + 64'd1;
      if (clint_sel && clint_wen && clint_addr[15:0] == 16'h4000) mtimecmp <= clint_wdata;
      if (clint_sel && !clint_wen) clint_rdata <= (clint_addr[15:0] == 16'hbff8) ? mtime : mtimecmp;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit dec_ok(input logic [63:0] a);
      return a[63:16] == 48'h0200 && (a[15:0] == 16'h4000 || a[15:0] == 16'hbff8);
   endfunction

   task automatic post(input int p, input logic [63:0] a, input logic w, input logic [63:0] d);
      req_v[p] = 1'b1;
      req_a[p] = a;
      req_w[p] = w;
      req_d[p] = d;
   endtask

   // one grant-to-response transaction; hold < 0 means a random response stall
   task automatic run_one(input int hold);
      int n, k, g, o, sel_n, d;
      bit ok;
      logic [63:0] a, wd, ret, exp_d, held;
      logic w;
      n = 0;
      do begin @(negedge clock); n++; end while (req_r == 2'b00 && n < 20);
      if (req_r == 2'b00) begin
         chk("grant_timeout", 64'(n), 64'd1);
         req_v = '0;
         return;
      end
      g = (req_v == 2'b11) ? 1 - last_m : (req_v[1] ? 1 : 0);
      o = 1 - g;
      chk("grant_gap", 64'(n), 64'd1);
      chk("grant", 64'(req_r), g ? 64'd2 : 64'd1);
      a = req_a[g]; w = req_w[g]; wd = req_d[g];
      ok = dec_ok(a);
      @(posedge clock); #1 req_v[g] = 1'b0;
      sel_n = 0; ret = '0;
      for (k = 1; k <= 6; k++) begin
         @(negedge clock);
         if (clint_sel) begin
            sel_n++;
            chk("clint_addr", clint_addr, a);
            chk("clint_wen", 64'(clint_wen), 64'(w));
            if (w) chk("clint_wdata", clint_wdata, wd);
         end else if (clint_wen) chk("wen_without_sel", 64'(clint_wen), 64'd0);
         if (k == 2 && ok) chk("clint_addr_wait", clint_addr, a);
         if (k == 2) ret = clint_rdata;
         if (req_r[o]) chk("other_ready", 64'(req_r[o]), 64'd0);
         if (rsp_v[g]) break;
      end
      chk("latency", 64'(k), ok ? 64'd3 : 64'd2);
      chk("sel_cycles", 64'(sel_n), ok ? 64'd1 : 64'd0);
      exp_d = (!ok || w) ? 64'd0 : (a[15:0] == 16'h4000 ? shadow_cmp : ret);
      chk("rdata", rsp_d[g], exp_d);
      chk("err", 64'(rsp_e[g]), 64'(!ok));
      chk("other_rsp", {rsp_v[o], rsp_e[o], rsp_d[o][61:0]}, 64'd0);
      if (ok && !w && a[15:0] == 16'hbff8) begin
         chk("mtime_monotonic", 64'(rsp_d[g] >= prev_mt), 64'd1);
         prev_mt = rsp_d[g];
      end
      held = rsp_d[g];
      d = hold < 0 ? int'($urandom_range(0, 3)) : hold;
      for (int i = 0; i < d; i++) begin
         @(negedge clock);
         chk("hold_valid", 64'(rsp_v[g]), 64'd1);
         chk("hold_rdata", rsp_d[g], held);
         chk("hold_other_ready", 64'(req_r[o]), 64'd0);
      end
      @(negedge clock) rsp_r[g] = 1'b1;
      @(posedge clock); #1 rsp_r[g] = 1'b0;
      if (ok && w && a[15:0] == 16'h4000) shadow_cmp = wd;
      last_m = g;
   endtask

   task automatic drain(input int hold);
      int guard;
      guard = 0;
      while (req_v != 2'b00 && guard < 4) begin run_one(hold); guard++; end
   endtask

   initial begin
      req_a = '{default: '0};
      req_d = '{default: '0};
      #12;
      chk("rst_outputs", {req_r, rsp_v, rsp_e, clint_sel, clint_wen}, 64'd0);
      chk("rst_addr", clint_addr | clint_wdata | rsp_d[0] | rsp_d[1], 64'd0);
      @(negedge clock) reset_n = 1'b1;
      @(posedge clock); #1;
      post(0, 64'h0200_4000, 1'b1, 64'h50); drain(0);
      post(0, 64'h0200_4000, 1'b0, 64'h0);  drain(0);
      post(0, 64'h0200_bff8, 1'b0, 64'h0);  post(1, 64'h0200_bff8, 1'b0, 64'h0); drain(-1);
      post(0, 64'h0200_bff8, 1'b0, 64'h0);  post(1, 64'h0200_bff8, 1'b0, 64'h0); drain(-1);
      post(1, 64'h0200_1000, 1'b0, 64'h0);  drain(1);
      post(1, 64'h0200_4004, 1'b0, 64'h0);  drain(1);
      post(0, 64'h0200_bff8, 1'b0, 64'h0);  post(1, 64'h0200_4000, 1'b0, 64'h0);
      run_one(5); drain(0);
      post(0, 64'h0200_bff8, 1'b0, 64'h0);  drain(0);
      post(0, 64'h0200_bff8, 1'b0, 64'h0);  drain(0);
      for (int it = 0; it < 60; it++) begin
         for (int p = 0; p < 2; p++) begin
            logic [63:0] a;
            logic w;
            a = addrs[$urandom_range(0, 4)];
            w = a[15:0] == 16'hbff8 ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) post(p, a, w, {$urandom, $urandom});
         end
         if (req_v == 2'b00) post(0, 64'h0200_4000, 1'b0, 64'h0);
         drain(-1);
      end
      post(0, 64'h0200_bff8, 1'b0, 64'h0); post(1, 64'h0200_bff8, 1'b0, 64'h0);
      @(negedge clock);
      @(posedge clock); #1 req_v = '0;
      @(negedge clock);
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1 chk("async_rst", {req_r, rsp_v, rsp_e, clint_sel, clint_wen}, 64'd0);
      chk("async_rst_data", clint_addr | clint_wdata | rsp_d[0] | rsp_d[1], 64'd0);
      last_m = 1;
      @(negedge clock) reset_n = 1'b1;
      chk("no_stale_rsp", 64'(rsp_v), 64'd0);
      @(posedge clock); #1;
      post(0, 64'h0200_bff8, 1'b0, 64'h0); post(1, 64'h0200_4000, 1'b0, 64'h0); drain(-1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/clint_bus_arbiter.md
Name: clint_bus_arbiter

Overview:
- Shares the single CLINT register port (mtime at offset 0xbff8, mtimecmp at offset 0x4000) between two requesters.
- Requester 0 is the core LSU MMIO path; requester 1 is the debug/host access path.
- Arbitrates round-robin, sequences one CLINT access at a time, and accounts for the CLINT's one-cycle registered read data.
- Returns data plus an error flag per requester over valid/ready handshakes.

Parameters:
- DATA_WIDTH, 64, width of address, write data and read data.
- CLINT_BASE, 64'h0000_0000_0200_0000, CLINT base address.
- CLINT_MASK, 64'hFFFF_FFFF_FFFF_0000, upper-bit mask used for the base match.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m0_req_valid  in  1  requester 0 request valid.
- m0_req_ready  out  1  requester 0 request accepted (1-cycle pulse).
- m0_req_addr  in  DATA_WIDTH  requester 0 byte address.
- m0_req_wdata  in  DATA_WIDTH  requester 0 write data.
- m0_req_wen  in  1  requester 0: 1 = write, 0 = read.
- m0_rsp_valid  out  1  requester 0 response valid.
- m0_rsp_ready  in  1  requester 0 response accept.
- m0_rsp_rdata  out  DATA_WIDTH  requester 0 read data (0 for writes and errors).
- m0_rsp_err  out  1  requester 0 decode error.
- m1_* (same nine signals as m0_*)  requester 1 equivalents.
- clint_addr  out  DATA_WIDTH  CLINT address.
- clint_wdata  out  DATA_WIDTH  CLINT write data.
- clint_wen  out  1  CLINT write enable.
- clint_sel  out  1  CLINT select.
- clint_rdata  in  DATA_WIDTH  CLINT read data, registered inside the CLINT, valid the cycle after clint_sel.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - All req_ready, rsp_valid, rsp_err, clint_sel and clint_wen = 0.
  - rsp_rdata, clint_addr and clint_wdata = 0.
  - Latched request registers cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant: when only one is valid, that one; when both are valid, the one != last_grant.
  - Assert the granted port's req_ready combinationally in the same cycle.
  - Latch addr, wdata, wen and grant id; go to ISSUE.
  - The non-granted port's req_ready stays 0 and its request must be held.
- Decode, computed on the latched address:
  - ok = ((addr & CLINT_MASK) == CLINT_BASE) && addr[2:0] == 0 && addr[15:0] ∈ {16'h4000, 16'hbff8}.
- ISSUE (one cycle):
  - If ok: clint_sel=1, clint_wen=latched wen, clint_addr and clint_wdata = latched values; go to WAIT.
  - If !ok: clint_sel=0, clint_wen=0, set err=1, rdata=0; go to RESP.
- WAIT (one cycle):
  - Capture clint_rdata into the response register for reads; capture 0 for writes. err=0. Go to RESP.
- RESP:
  - Only the granted port's rsp_valid=1; its rsp_rdata and rsp_err are held stable.
  - The other port's rsp_valid=0 and its rsp_rdata and rsp_err are 0.
  - On rsp_ready=1: last_grant=grant id, go to IDLE.
  - Until then, hold indefinitely with no new grant.
- clint_sel and clint_wen are asserted only in ISSUE. clint_addr and clint_wdata are held at the latched values outside ISSUE (clint_addr does not change during WAIT).
- Latency: handshake in cycle N → clint_sel in N+1 → capture in N+2 → rsp_valid from N+3. Error path: rsp_valid from N+2.
- Throughput: at most one transaction outstanding. A new grant is possible in the cycle after the rsp handshake, since IDLE is re-entered.
- Simultaneous new request during RESP: ignored until IDLE; no req_ready pulse.
- Reset mid-transaction: the transaction is aborted, no response is produced, and the pending rsp_valid is cleared immediately.
- A requester dropping req_valid before req_ready is permitted; it is simply not granted.

Test Plan:
- m0 write 64'h50 to 0x0200_4000, then m0 read 0x0200_4000 → clint_sel=1,clint_wen=1,clint_wdata=64'h50 for exactly one cycle, then clint_sel=1,clint_wen=0; first response (write): rsp_rdata=0, rsp_err=0; second response (read): m0_rsp_valid at N+3, rsp_rdata=64'h50, rsp_err=0.
- Both requesters valid in the same IDLE cycle after reset, reading 0x0200_bff8 → m0 granted first; after its rsp handshake, m1 granted next; then both again → m0 (alternation holds).
- m1 read of 0x0200_1000 (and separately 0x0200_4004) → clint_sel never asserted, m1_rsp_valid at N+2, rsp_err=1, rsp_rdata=0.
- m0 read of 0x0200_bff8 with m0_rsp_ready held 0 for 5 cycles while m1_req_valid=1 → m0_rsp_valid and rsp_rdata stable for all 5 cycles, m1_req_ready=0 throughout; m1 granted the cycle after the handshake.
- reset asserted while in WAIT → all outputs go to 0 asynchronously; after release, m0 wins a tie and no stale rsp_valid appears.
- Back-to-back m0 reads of mtime with the CLINT ticking → second rdata ≥ first; each response matches the clint_rdata value present in its WAIT cycle.
